// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: two valid/ready FIFOs (ALU, MEM) drained one write per cycle into a registered regfile write port.
// Define REGWRITE_MEM_PRIORITY_EN for fixed MEM-first arbitration; default is round-robin.
module regwrite_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    output logic              regwrite,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] write_data,
    output logic              stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // index 0 is the ALU requester, index 1 the MEM requester
    logic [1:0]        in_valid, rdy, push, pop, nempty;
    logic [ADDR_W-1:0] in_dest [2];
    logic [DATA_W-1:0] in_data [2];
    logic [ADDR_W-1:0] fdest_q [2][DEPTH];
    logic [DATA_W-1:0] fdata_q [2][DEPTH];
    logic [PW-1:0]     wp_q [2];
    logic [PW-1:0]     rp_q [2];
    logic [CW-1:0]     cnt_q [2];
    logic              grant_alu, grant_mem;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              stall_c;

    assign in_valid   = {mem_valid, alu_valid};
    assign in_dest[0] = alu_dest;
    assign in_dest[1] = mem_dest;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign rdy        = {cnt_q[1] < FULL, cnt_q[0] < FULL};
    assign nempty     = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign push       = in_valid & rdy;

`ifdef REGWRITE_MEM_PRIORITY_EN
    assign grant_mem = nempty[1];
    assign grant_alu = nempty[0] & ~nempty[1];
`else
    logic last_mem_q, last_mem_d;
    assign grant_alu  = nempty[0] & (~nempty[1] | last_mem_q);
    assign grant_mem  = nempty[1] & ~grant_alu;
    assign last_mem_d = |pop ? grant_mem : last_mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_mem_q <= 1'b1;
        else       last_mem_q <= last_mem_d;
    end
`endif

    assign pop        = {grant_mem, grant_alu};
    assign head_dest  = grant_mem ? fdest_q[1][rp_q[1]] : fdest_q[0][rp_q[0]];
    assign head_data  = grant_mem ? fdata_q[1][rp_q[1]] : fdata_q[0][rp_q[0]];
    assign regwrite_d = |pop && head_dest != '0;
    assign dest_d     = |pop ? head_dest : dest_q;
    assign wdata_d    = |pop ? head_data : wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 2; r++) begin
                wp_q[r]  <= '0;
                rp_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) wp_q[r] <= wp_q[r] + PW'(1);
                if (pop[r])  rp_q[r] <= rp_q[r] + PW'(1);
                cnt_q[r] <= cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                fdest_q[r][wp_q[r]] <= in_dest[r];
                fdata_q[r][wp_q[r]] <= in_data[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            dest_q     <= '0;
            wdata_q    <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            dest_q     <= dest_d;
            wdata_q    <= wdata_d;
        end
    end

    // an entry is live when its offset from the read pointer is below the count
    always_comb begin
        stall_c = regwrite_q && (dest_q == address1 || dest_q == address2);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ({1'b0, PW'(i) - rp_q[r]} < cnt_q[r] && fdest_q[r][i] != '0 &&
                    (fdest_q[r][i] == address1 || fdest_q[r][i] == address2))
                    stall_c = 1'b1;
            end
        end
    end

    assign alu_ready  = rdy[0];
    assign mem_ready  = rdy[1];
    assign regwrite   = regwrite_q;
    assign dest       = dest_q;
    assign write_data = wdata_q;
    assign stall      = stall_c;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed vectors for regwrite_arbiter; expectations follow REGWRITE_MEM_PRIORITY_EN when defined.
module tb_regwrite_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready, regwrite, stall;
    logic [4:0]  alu_dest = '0, mem_dest = '0, address1 = '0, address2 = '0, dest;
    logic [31:0] alu_data = '0, mem_data = '0, write_data;
    int          vecs = 0, errs = 0;
    int          n;
    logic [63:0] exp_d [4];
    logic [63:0] exp_w [4];

    regwrite_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .address1(address1), .address2(address2),
        .regwrite(regwrite), .dest(dest), .write_data(write_data), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REGWRITE_MEM_PRIORITY_EN
        exp_d = '{64'd4, 64'd3, 64'd4, 64'd3};
        exp_w = '{64'h40, 64'h30, 64'h41, 64'h31};
`else
        exp_d = '{64'd3, 64'd4, 64'd3, 64'd4};
        exp_w = '{64'h30, 64'h40, 64'h31, 64'h41};
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_regwrite", regwrite, 0);
        check("rst_dest", dest, 0);
        check("rst_wdata", write_data, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_stall", stall, 0);

        // single ALU write
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hAA;
        step();
        alu_valid = 1'b0;
        check("t2_not_yet", regwrite, 0);
        step();
        check("t2_we", regwrite, 1);
        check("t2_dest", dest, 5);
        check("t2_data", write_data, 32'hAA);
        step();
        check("t2_we_off", regwrite, 0);
        check("t2_dest_hold", dest, 5);

        // reset with buffered entries and a write in flight
        alu_valid = 1'b1; alu_dest = 5'd14; alu_data = 32'hE;
        mem_valid = 1'b1; mem_dest = 5'd16; mem_data = 32'h10;
        address1 = 5'd17;
        step();
        alu_dest = 5'd15; mem_dest = 5'd17;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        check("t1_one_full", alu_ready & mem_ready, 0);
        check("t1_stall_pre", stall, 1);
        check("t1_we_pre", regwrite, 1);
        #1 reset = 1'b1;
        #1;
        check("t1_rst_we", regwrite, 0);
        check("t1_rst_ready", {alu_ready, mem_ready}, 2'b11);
        check("t1_rst_stall", stall, 0);
        step();
        reset = 1'b0;
        address1 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_no_write", regwrite, 0);
        end

        // simultaneous pushes, then a second pair two cycles later
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h30;
        mem_valid = 1'b1; mem_dest = 5'd4; mem_data = 32'h40;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("t3_idle", regwrite, 0);
        step();
        check("t3_we0", regwrite, 1);
        check("t3_dest0", dest, exp_d[0]);
        check("t3_data0", write_data, exp_w[0]);
        alu_valid = 1'b1; alu_data = 32'h31;
        mem_valid = 1'b1; mem_data = 32'h41;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (i > 1) step();
            check("t3_we", regwrite, 1);
            check("t3_dest", dest, exp_d[i]);
            check("t3_data", write_data, exp_w[i]);
        end
        step();
        check("t3_done", regwrite, 0);

        // back-to-back ALU pushes against a busy MEM FIFO
        alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'h1;
        step();
        alu_valid = 1'b0;
        step();
        check("t4_pre", dest, 1);
        alu_valid = 1'b1; alu_dest = 5'd11; alu_data = 32'hB0;
        mem_valid = 1'b1; mem_dest = 5'd20; mem_data = 32'h20;
        step();
        alu_dest = 5'd12; alu_data = 32'hB1;
        mem_dest = 5'd21; mem_data = 32'h21;
        step();
        check("t4_alu_full", alu_ready, 0);
        check("t4_mem_ready", mem_ready, 1);
        check("t4_mem_first", dest, 20);
        alu_dest = 5'd13; alu_data = 32'hB2;
        mem_valid = 1'b0;
        n = 0;
        while (!alu_ready && n < 5) begin
            step();
            n++;
        end
        check("t4_ready_back", alu_ready, 1);
        check("t4_pop_we", regwrite, 1);
        check("t4_pop_dest", dest, 11);
        step();
        alu_valid = 1'b0;
        n = 0;
        while (!(regwrite && dest == 5'd12) && n < 5) begin
            step();
            n++;
        end
        check("t4_b1_we", regwrite, 1);
        check("t4_b1_data", write_data, 32'hB1);
        step();
        check("t4_b2_dest", dest, 13);
        check("t4_b2_data", write_data, 32'hB2);
        step();
        check("t4_done", regwrite, 0);

        // write to r0 is consumed but suppressed
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFF_FFFF;
        address1 = 5'd0; address2 = 5'd0;
        step();
        alu_valid = 1'b0;
        check("t5_stall_q", stall, 0);
        step();
        check("t5_we", regwrite, 0);
        check("t5_data", write_data, 32'hFFFF_FFFF);
        check("t5_stall_w", stall, 0);
        check("t5_drained", alu_ready, 1);
        step();
        check("t5_we_after", regwrite, 0);

        // hazard on a pending MEM write to r7
        address1 = 5'd8; address2 = 5'd7;
        #1;
        check("t6_stall_empty", stall, 0);
        mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h77;
        step();
        mem_valid = 1'b0;
        check("t6_stall_q", stall, 1);
        address2 = 5'd9;
        #1;
        check("t6_nomatch", stall, 0);
        address2 = 5'd7;
        step();
        check("t6_we", regwrite, 1);
        check("t6_dest", dest, 7);
        check("t6_stall_w", stall, 1);
        address1 = 5'd7; address2 = 5'd8;
        #1;
        check("t6_stall_a1", stall, 1);
        step();
        check("t6_we_off", regwrite, 0);
        check("t6_stall_off", stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
